// File: rtl/load_store_unit.sv
// RV32I load/store unit: computes the effective address, screens width and
// alignment, issues a single memory request and returns the extended load result.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_store,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_base,
  input  logic [11:0]       op_offset,
  input  logic [WORD_W-1:0] op_st_data,
  output logic              done,
  output logic [WORD_W-1:0] ld_data,
  output logic [1:0]        exc,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              mem_req,
  output logic              mem_write_en,
  output logic [1:0]        mem_n_bytes,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_w_data,
  input  logic              mem_addr_err,
  input  logic [WORD_W-1:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ALIGN   = 2'b01;
  localparam logic [1:0] EXC_ACCESS  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL = 2'b11;

  state_t            state;
  logic              st_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] ea_q;

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] ea;
  logic              illegal;
  logic              misaligned;
  logic [WORD_W-1:0] ld_ext;

  assign off_ext = {{(ADDR_W-12){op_offset[11]}}, op_offset};
  assign ea      = op_base + off_ext;

  // Screening happens on the raw request so faults can complete without a memory trip.
  always_comb begin
    illegal = 1'b0;
    if (op_store)
      illegal = op_funct3[2] | (op_funct3 == 3'b011);
    else
      illegal = (op_funct3 == 3'b011) | (op_funct3 == 3'b110) | (op_funct3 == 3'b111);
  end

  always_comb begin
    misaligned = 1'b0;
    case (op_funct3[1:0])
      2'b01:   misaligned = ea[0];
      2'b10:   misaligned = (ea[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    ld_ext = '0;
    case (funct3_q)
      3'b000:  ld_ext = {{(WORD_W-8){mem_r_data[7]}}, mem_r_data[7:0]};
      3'b001:  ld_ext = {{(WORD_W-16){mem_r_data[15]}}, mem_r_data[15:0]};
      3'b010:  ld_ext = mem_r_data;
      3'b100:  ld_ext = {{(WORD_W-8){1'b0}}, mem_r_data[7:0]};
      3'b101:  ld_ext = {{(WORD_W-16){1'b0}}, mem_r_data[15:0]};
      default: ld_ext = '0;
    endcase
  end

  // Result registers only change on entry to DONE, so they hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_ready     <= 1'b1;
      done         <= 1'b0;
      mem_req      <= 1'b0;
      mem_write_en <= 1'b0;
      mem_n_bytes  <= 2'b00;
      mem_addr     <= '0;
      mem_w_data   <= '0;
      ld_data      <= '0;
      exc          <= EXC_NONE;
      fault_addr   <= '0;
      st_q         <= 1'b0;
      funct3_q     <= 3'b000;
      ea_q         <= '0;
    end else begin
      done         <= 1'b0;
      mem_req      <= 1'b0;
      mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_ready <= 1'b0;
            st_q     <= op_store;
            funct3_q <= op_funct3;
            ea_q     <= ea;
            if (illegal || misaligned) begin
              state      <= DONE;
              done       <= 1'b1;
              exc        <= illegal ? EXC_ILLEGAL : EXC_ALIGN;
              fault_addr <= ea;
              ld_data    <= '0;
            end else begin
              state        <= ISSUE;
              mem_req      <= 1'b1;
              mem_write_en <= op_store;
              mem_n_bytes  <= op_funct3[1:0] + 2'd1;
              mem_addr     <= ea;
              mem_w_data   <= op_st_data;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          state <= DONE;
          done  <= 1'b1;
          if (mem_addr_err) begin
            exc        <= EXC_ACCESS;
            fault_addr <= ea_q;
            ld_data    <= '0;
          end else begin
            exc        <= EXC_NONE;
            fault_addr <= '0;
            ld_data    <= st_q ? '0 : ld_ext;
          end
        end
        DONE: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of the data-memory port.
REQ-002 SHALL have parameter WORD_W, default 32, meaning data word width.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 SHALL have port op_valid, input, 1, meaning the core presents a memory operation.
REQ-006 SHALL have port op_ready, output, 1, meaning the unit accepts an operation this cycle.
REQ-007 SHALL have port op_store, input, 1, meaning 1 is a store and 0 is a load.
REQ-008 SHALL have port op_funct3, input, 3, meaning the RV32I width/sign field (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 SHALL have port op_base, input, ADDR_W, meaning the rs1 value.
REQ-010 SHALL have port op_offset, input, 12, meaning the signed immediate.
REQ-011 SHALL have port op_st_data, input, WORD_W, meaning the rs2 value.
REQ-012 SHALL have port done, output, 1, meaning a one-cycle completion pulse.
REQ-013 SHALL have port ld_data, output, WORD_W, meaning the extended load result.
REQ-014 SHALL have port exc, output, 2, meaning exception code: 00 none, 01 misaligned, 10 access fault, 11 illegal width.
REQ-015 SHALL have port fault_addr, output, ADDR_W, meaning the effective address of the faulting operation.
REQ-016 SHALL have port mem_req, output, 1, meaning the data-memory request.
REQ-017 SHALL have port mem_write_en, output, 1, meaning the request is a write.
REQ-018 SHALL have port mem_n_bytes, output, 2, meaning access size: 01 byte, 10 half, 11 word.
REQ-019 SHALL have port mem_addr, output, ADDR_W, meaning the byte address.
REQ-020 SHALL have port mem_w_data, output, WORD_W, meaning store data, with the byte at mem_addr in bits [7:0].
REQ-021 SHALL have port mem_addr_err, input, 1, meaning the memory's registered error flag, valid one cycle after mem_req.
REQ-022 SHALL have port mem_r_data, input, WORD_W, meaning the memory's registered read data, valid one cycle after mem_req, little-endian from mem_addr.

Function
REQ-023 SHALL implement an FSM with states IDLE, ISSUE, WAIT, DONE; op_ready=1 only in IDLE.
REQ-024 SHALL accept an operation on op_valid&op_ready (cycle 0) and register op_store, op_funct3, op_st_data, and ea = op_base + sign-extended op_offset, modulo 2^ADDR_W with carry discarded.
REQ-025 SHALL flag illegal width for loads with funct3 in {011,110,111} and stores with funct3[2]=1 or funct3=011; such operations SHALL go IDLE->DONE with exc=11 and no mem_req.
REQ-026 SHALL flag misalignment when a half access has ea[0]=1 or a word access has ea[1:0]!=00; such operations SHALL go IDLE->DONE with exc=01 and no mem_req.
REQ-027 SHALL otherwise go IDLE->ISSUE and assert mem_req for exactly one cycle (cycle 1) with mem_addr=ea, mem_write_en=op_store, mem_n_bytes=funct3[1:0]+1, and mem_w_data=op_st_data.
REQ-028 SHALL hold mem_req=0 and mem_write_en=0 in every state except ISSUE.
REQ-029 SHALL sample mem_r_data and mem_addr_err in WAIT (cycle 2), then go to DONE.
REQ-030 SHALL assert done in DONE for one cycle (cycle 3 for memory operations, cycle 1 for early faults), then return to IDLE.
REQ-031 SHALL produce load data as follows: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through; stores drive ld_data=0.
REQ-032 SHALL report mem_addr_err=1 as exc=10 with ld_data=0.
REQ-033 SHALL set fault_addr=ea when exc!=00, and fault_addr=0 otherwise.
REQ-034 SHALL hold ld_data, exc, and fault_addr stable from the DONE cycle until the next DONE.
REQ-035 SHALL ignore op_valid while op_ready=0.
REQ-036 SHALL sample mem_r_data and mem_addr_err only in WAIT and ignore them in all other states.

Reset
REQ-037 SHALL, when rst=1 at a clock edge in any state, enter IDLE and drop any pending operation with no done pulse; a memory response following an aborted ISSUE SHALL be ignored.
REQ-038 SHALL set the following values after reset: op_ready=1, done=0, mem_req=0, mem_write_en=0, mem_n_bytes=00, mem_addr=0, mem_w_data=0, ld_data=0, exc=00, fault_addr=0.

Verification
REQ-039 SHALL cover: LB with base=0x4000, offset=-1, and mem_r_data=0x000000F0 -> mem_addr=0x3FFF, mem_n_bytes=01 at cycle 1; done at cycle 3 with ld_data=0xFFFFFFF0 and exc=00.
REQ-040 SHALL cover: LHU at ea=0x4002 with mem_r_data=0x0000_8001 -> ld_data=0x00008001; LH at the same ea -> ld_data=0xFFFF8001.
REQ-041 SHALL cover: SW at ea=0x4006 -> no mem_req; done at cycle 1 with exc=01 and fault_addr=0x4006.
REQ-042 SHALL cover: SB at ea=0x4010 with op_st_data=0xAABBCCDD -> mem_write_en=1, n_bytes=01, w_data=0xAABBCCDD; done at cycle 3 with exc=00.
REQ-043 SHALL cover: LW with mem_addr_err=1 in WAIT -> exc=10, ld_data=0; also LW with funct3=011 -> exc=11 and no mem_req.
REQ-044 SHALL cover: rst asserted in WAIT -> next cycle IDLE, op_ready=1, no done pulse; op_valid held during ISSUE/WAIT not accepted.
